// File: rtl/led_pkg.sv
// Shared helpers for the LED afterglow fader: LED count, pin polarity mapping
// and the decay prescaler divisor.
package led_pkg;

  localparam int LED_N = 8;

  // Maps a logical on/off request onto the physical pin level.
  function automatic logic pin_level(input logic on, input logic polarity);
    return on ? polarity : ~polarity;
  endfunction

  // Clock cycles per decay tick; simulation builds shorten it so decay is observable.
  function automatic int decay_div(input int clk_in_mhz, input int decay_hz);
    int div;
    div = (clk_in_mhz * 1000000) / decay_hz;
`ifdef SIM
    div = 16;
`endif
    return div;
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// LED pattern in / PWM drive out bundle between the sweep sequencer, the fader
// and the board pins.
interface led_fader_if;
  import led_pkg::*;

  logic [LED_N-1:0] led_i;
  logic [LED_N-1:0] led_o;
  logic             period_start_o;

  modport master (output led_i, input led_o, input period_start_o);
  modport slave  (input led_i, output led_o, output period_start_o);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED: intensity register with snap-to-full / saturating decay, a shadow
// copy reloaded at period boundaries, and the registered PWM compare.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int   PWM_BITS     = 8,
  parameter int   DECAY_STEP   = 32,
  parameter logic LED_POLARITY = 1'b0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                lit_i,
  input  logic                decay_tc_i,
  input  logic                load_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);

  typedef logic [PWM_BITS-1:0] intensity_t;

  localparam intensity_t MAX  = '1;
  localparam intensity_t STEP = intensity_t'(DECAY_STEP);

  function automatic intensity_t sat_sub(input intensity_t a);
    return (a < STEP) ? '0 : a - STEP;
  endfunction

  intensity_t intensity_q, intensity_d;
  intensity_t shadow_q, shadow_d;
  logic       led_q, led_d;

  always_comb begin
    intensity_d = intensity_q;
    if (lit_i) begin
      intensity_d = MAX;
    end else if (decay_tc_i) begin
      intensity_d = sat_sub(intensity_q);
    end
    // Duty only changes between periods so the current period never glitches.
    shadow_d = load_i ? intensity_q : shadow_q;
    led_d    = pin_level(shadow_q > pwm_cnt_i, LED_POLARITY);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      intensity_q <= '0;
      shadow_q    <= '0;
      led_q       <= pin_level(1'b0, LED_POLARITY);
    end else begin
      intensity_q <= intensity_d;
      shadow_q    <= shadow_d;
      led_q       <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// PWM afterglow fader: lit inputs snap an LED to full brightness, unlit LEDs
// decay in fixed steps. Owns the shared PWM counter and decay prescaler.
module led_fader
  import led_pkg::*;
#(
  parameter int   CLK_IN_MHZ   = 125,
  parameter logic IN_POLARITY  = 1'b0,
  parameter logic LED_POLARITY = 1'b0,
  parameter int   PWM_BITS     = 8,
  parameter int   DECAY_HZ     = 64,
  parameter int   DECAY_STEP   = 32
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  led_fader_if.slave bus
);

  localparam int P         = (1 << PWM_BITS) - 1;
  localparam int DECAY_DIV = decay_div(CLK_IN_MHZ, DECAY_HZ);
  localparam int PRE_W     = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  typedef logic [PWM_BITS-1:0] cnt_t;
  typedef logic [PRE_W-1:0]    pre_t;

  localparam cnt_t CNT_LAST = cnt_t'(P - 1);
  localparam pre_t PRE_LAST = pre_t'(DECAY_DIV - 1);

  if (DECAY_STEP > P) begin : g_step_chk
    $fatal(1, "DECAY_STEP must not exceed the maximum intensity");
  end

  cnt_t             pwm_cnt_q, pwm_cnt_d;
  pre_t             pre_q, pre_d;
  logic             period_start_q, period_start_d;
  logic             decay_tc;
  logic             load;
  logic [LED_N-1:0] lit;
  logic [LED_N-1:0] led_w;

  always_comb begin
    // The counter wraps at P-1 so a full-scale shadow (MAX) is on every cycle.
    pwm_cnt_d      = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + cnt_t'(1);
    decay_tc       = (pre_q == PRE_LAST);
    pre_d          = decay_tc ? '0 : pre_q + pre_t'(1);
    period_start_d = (pwm_cnt_q == '0);
    load           = (pwm_cnt_q == CNT_LAST);
    lit            = '0;
    for (int n = 0; n < LED_N; n++) begin
      lit[n] = (bus.led_i[n] == IN_POLARITY);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_cnt_q      <= '0;
      pre_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      pre_q          <= pre_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar n = 0; n < LED_N; n++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS    (PWM_BITS),
      .DECAY_STEP  (DECAY_STEP),
      .LED_POLARITY(LED_POLARITY)
    ) u_ch (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .lit_i     (lit[n]),
      .decay_tc_i(decay_tc),
      .load_i    (load),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led_w[n])
    );
  end

  assign bus.led_o          = led_w;
  assign bus.period_start_o = period_start_q;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader with PWM_BITS=4, DECAY_STEP=4, a 16-cycle decay tick and
// active-low input and output polarity.
`timescale 1ns/1ps
module tb_led_fader;

  localparam int P    = 15;
  localparam int DIV  = 16;
  localparam int STEP = 4;
  localparam int MAXI = 15;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  led_fader_if bus ();

  led_fader #(
    .CLK_IN_MHZ  (1),
    .IN_POLARITY (1'b0),
    .LED_POLARITY(1'b0),
    .PWM_BITS    (4),
    .DECAY_HZ    (62500),
    .DECAY_STEP  (4)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;

  // Reference: time since reset release (edges) fixes the PWM phase and decay ticks.
  int         inten [8];
  int         shad  [8];
  logic [7:0] exp_led = 8'hFF;
  logic       exp_ps  = 1'b0;
  int         edges   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int n = 0; n < 8; n++) begin
          inten[n] = 0;
          shad[n]  = 0;
        end
        exp_led = 8'hFF;
        exp_ps  = 1'b0;
        edges   = 0;
      end else begin
        int  pc;
        bit  tick;
        pc   = edges % P;
        tick = ((edges % DIV) == DIV - 1);
        for (int n = 0; n < 8; n++) begin
          exp_led[n] = (shad[n] > pc) ? 1'b0 : 1'b1;
          if (pc == P - 1) shad[n] = inten[n];
          if (bus.led_i[n] == 1'b0) inten[n] = MAXI;
          else if (tick) inten[n] = (inten[n] < STEP) ? 0 : inten[n] - STEP;
        end
        exp_ps = (pc == 0);
        edges++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("led_o", bus.led_o, exp_led);
        check("period_start_o", bus.period_start_o, exp_ps);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded 500us, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ps(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.period_start_o === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Counts "on" cycles of one LED over the period whose start strobe is visible now.
  task automatic period_on(input int b, output int cnt);
    cnt = (bus.led_o[b] === 1'b0) ? 1 : 0;
    repeat (P - 1) begin
      @(negedge clk);
      if (bus.led_o[b] === 1'b0) cnt++;
    end
  endtask

  bit   ok;
  int   cnt, on, pre, got_max, e, exp_lat;
  int   seq[$];
  int   exp_seq[4] = '{11, 7, 3, 0};

  initial begin
    bus.led_i = 8'hFF;
    rstn      = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_led_o", bus.led_o, 8'hFF);
    check("reset_period_start", bus.period_start_o, 1'b0);

    // Strobe period after release.
    rstn = 1'b1;
    wait_ps(ok);
    check("first_strobe_seen", ok, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.period_start_o === 1'b1) break;
    end
    check("strobe_spacing", cnt, P);

    // LED0 held lit: full-on periods, others dark.
    bus.led_i = 8'hFE;
    repeat (40) @(negedge clk);
    wait_ps(ok);
    period_on(0, cnt);
    check("held_lit_full_on", cnt, 15);
    check("unlit_leds_off", bus.led_o[7:1], 7'h7F);

    // Release: per-period duty steps 11, 7, 3, 0 with no wrap.
    bus.led_i = 8'hFF;
    seq.delete();
    for (int k = 0; k < 8; k++) begin
      wait_ps(ok);
      if (!ok) break;
      period_on(0, cnt);
      if (!(cnt == 15 && seq.size() == 0) && (seq.size() == 0 || seq[$] != cnt))
        seq.push_back(cnt);
    end
    check("decay_steps", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("decay_value", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
    check("decay_floor", cnt, 0);

    // Lit on the decay tick while at 7: lit wins.
    bus.led_i = 8'hF7;
    repeat (20) @(negedge clk);
    bus.led_i = 8'hFF;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inten[3] == 7 && (edges % DIV) == DIV - 1) begin
        ok = 1;
        break;
      end
    end
    check("tick_alignment_found", ok, 1);
    bus.led_i = 8'hF7;
    @(negedge clk);
    bus.led_i = 8'hFF;
    check("model_lit_wins", inten[3], 15);
    got_max = 0;
    for (int k = 0; k < 2; k++) begin
      wait_ps(ok);
      period_on(3, cnt);
      if (cnt > got_max) got_max = cnt;
    end
    check("lit_beats_decay", got_max, 15);

    // LED5 lit mid-period from shadow 0.
    check("led5_idle_model", shad[5], 0);
    for (int i = 0; i < 40; i++) begin
      if ((edges % P) == 6) break;
      @(negedge clk);
    end
    bus.led_i = 8'hDF;
    pre = 0;
    on  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.period_start_o === 1'b1) break;
      pre++;
      if (bus.led_o[5] === 1'b0) on++;
    end
    check("mid_period_stays_off", on, 0);
    check("mid_period_remaining", pre, 9);
    period_on(5, cnt);
    check("next_period_full_on", cnt, 15);

    // Mixed intensities, then asynchronous reset.
    bus.led_i = 8'hF8;
    repeat (20) @(negedge clk);
    bus.led_i = 8'hFE;
    repeat (20) @(negedge clk);
    bus.led_i = 8'hFF;
    #2 rstn = 1'b0;
    #1;
    check("async_reset_led_o", bus.led_o, 8'hFF);
    check("async_reset_strobe", bus.period_start_o, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    on = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.led_o !== 8'hFF) on++;
    end
    check("dark_after_reset", on, 0);

    // Lit-to-on latency follows the period phase, at most P+2.
    e       = edges;
    exp_lat = ((13 - (e % P) + P) % P) + 1 + 2;
    bus.led_i = 8'h7F;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.led_o[7] === 1'b0) break;
    end
    check("lit_to_on_latency", cnt, exp_lat);
    check("latency_bound", (cnt <= P + 2), 1);

    // Randomized patterns, sweeps and one mid-run reset.
    for (int s = 0; s < 80; s++) begin
      if (s == 40) begin
        #($urandom_range(1, 4)) rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
      end
      if ((s % 4) == 3) begin
        for (int k = 0; k < 16; k++) begin
          bus.led_i = ~(8'h01 << ((k < 8) ? k : 15 - k));
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
      end else begin
        bus.led_i = 8'($urandom);
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    bus.led_i = 8'hFF;
    repeat (80) @(negedge clk);

    chk_en = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Sits directly downstream of the KITT sweep sequencer and consumes its 8-bit LED pattern.
- Turns the hard on/off pattern into a PWM-dimmed "afterglow" trail:
  - a lit input snaps that LED to full intensity;
  - an unlit LED then decays in fixed steps at a fixed rate.
- Its outputs drive the board LED pins in place of the raw pattern.

Parameters:
- CLK_IN_MHZ, 125, input clock frequency in MHz.
- IN_POLARITY, 1'b0, level of led_i that means "LED lit". The default accepts the sequencer's default active-low output.
- LED_POLARITY, 1'b0, level of led_o that turns an LED on. 0 = active-low board LEDs.
- PWM_BITS, 8, intensity/PWM resolution. MAX = 2^PWM_BITS-1.
- DECAY_HZ, 64, decay ticks per second.
- DECAY_STEP, 32, intensity subtracted per decay tick.

Ports:
- clk_i, input, 1, system clock.
- rstn_i, input, 1, asynchronous active-low reset.
- led_i, input, 8, LED pattern from sequencer, synchronous to clk_i, no synchroniser.
- led_o, output, 8, PWM-modulated LED drive, registered.
- period_start_o, output, 1, one-cycle strobe when pwm_cnt==0 (bench/debug).

Behaviour:
- Reset is asynchronous, active-low; clock is clk_i.
- Reset values:
  - pwm_cnt=0, decay prescaler=0;
  - all intensity[n]=0, all shadow[n]=0;
  - led_o = all off, i.e. {8{~LED_POLARITY}};
  - period_start_o=0.
- Reset mid-operation: all of the above take effect immediately (async), and outputs go to off.
- PWM counter:
  - pwm_cnt counts 0..P-1 with P=MAX (2^PWM_BITS-1), then wraps to 0.
  - period_start_o is registered and asserted the cycle after pwm_cnt==0 is reached.
- Decay tick:
  - Prescaler counts 0..DECAY_DIV-1, DECAY_DIV = CLK_IN_MHZ*1e6/DECAY_HZ.
  - decay_tc is asserted for one cycle at terminal count.
  - Under `SIM`, DECAY_DIV is forced to 16.
- Per-LED intensity update, each cycle, for each n:
  - lit = (led_i[n]==IN_POLARITY).
  - If lit: intensity <= MAX.
  - Else if decay_tc: intensity <= (intensity < DECAY_STEP) ? 0 : intensity-DECAY_STEP. This saturates at 0 with no wrap.
  - Else: hold.
  - lit and decay_tc in the same cycle: lit wins, intensity = MAX.
- Shadow (glitch-free duty):
  - shadow[n] <= intensity[n] only on cycles where pwm_cnt==P-1.
  - Duty therefore changes only at period boundaries; changes mid-period do not affect the current period.
- Output:
  - led_o[n] <= (shadow[n] > pwm_cnt) ? LED_POLARITY : ~LED_POLARITY.
  - This adds one cycle of register latency after the compare.
  - shadow=MAX gives 100% on; shadow=0 gives always off; otherwise duty = shadow/P.
- Latency, lit input to first "on" output: intensity at t+1; then the shadow load at the next pwm_cnt==P-1; then led_o one cycle after pwm_cnt==0. Worst case is P+2 cycles.
- Arithmetic is unsigned PWM_BITS wide. DECAY_STEP must be ≤ MAX; an elaboration-time assertion checks this.

Decomposition:
- Shared package led_pkg holds:
  - the intensity type logic [PWM_BITS-1:0] (parameterised via localparam in the module);
  - the function that maps logical on/off to pin level given polarity;
  - the DECAY_DIV computation, including the `SIM override.
- Sub-module led_pwm_channel, instantiated 8×. It holds one LED's intensity register, shadow register and comparator.
- The top level owns pwm_cnt, the decay prescaler and period_start_o.

Test Plan (PWM_BITS=4 → MAX=P=15, DECAY_STEP=4, `SIM so DECAY_DIV=16, IN_POLARITY=0, LED_POLARITY=0):
1. Assert rstn_i with led_i=8'hFF → led_o=8'hFF immediately; period_start_o=0; pulses then every 15 cycles after release.
2. led_i=8'hFE held → from the first period after the shadow load, led_o[0]=0 for all 15 cycles of every period; led_o[7:1]=7'h7F throughout.
3. Release to led_i=8'hFF → led_o[0] low-duty per period follows shadow 11, 7, 3, 0 (i.e. 11/15, 7/15, 3/15, then constant high); never wraps past 0.
4. Drive led_i[3] lit exactly on the decay_tc cycle while intensity=7 → intensity=15, not 11.
5. Light led_i[5] at pwm_cnt=6 of a period with shadow=0 → led_o[5] stays high for the rest of that period; full-on from the next period.
6. Reset pulse mid-sweep with several LEDs at intensities 15/11/7 → led_o=8'hFF asynchronously; after release all stay off until led_i lights them again. Integration run with the sequencer under `SIM shows a decaying trail behind the lit LED.
